// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive front end.
// No logic; state encoding, prescale floor and parity sense only.
// Imported by the controller, the bit sampler and the bench.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int   PRESC_MIN = 8;
    localparam logic EVEN      = 1'b0;
    localparam logic ODD       = 1'b1;

endpackage

// File: rtl/uart_rx_data_sampler.sv
// Purpose: 3-sample majority vote of rx_sync around the bit midpoint.
// Latency: sampled_bit registered on the cycle where edge_cnt == P/2+1.
// Backpressure: none; free-running against the controller's edge counter.
module uart_rx_data_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESC_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_sync,
    input  logic [PRESC_W-1:0] edge_cnt,
    input  logic [PRESC_W-1:0] presc,
    output logic               sampled_bit
);

    localparam logic [PRESC_W-1:0] ONE = PRESC_W'(1);

    logic [PRESC_W-1:0] mid;
    logic [PRESC_W-1:0] mid_lo;
    logic [PRESC_W-1:0] mid_hi;
    logic               s_lo;
    logic               s_mid;

    assign mid    = presc >> 1;
    assign mid_lo = mid - ONE;
    assign mid_hi = mid + ONE;

    // The third sample is taken live from rx_sync as the vote is registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_lo        <= 1'b0;
            s_mid       <= 1'b0;
            sampled_bit <= 1'b0;
        end else begin
            if (edge_cnt == mid_lo) s_lo  <= rx_sync;
            if (edge_cnt == mid)    s_mid <= rx_sync;
            if (edge_cnt == mid_hi)
                sampled_bit <= (s_lo & s_mid) | (s_lo & rx_sync) | (s_mid & rx_sync);
        end
    end

endmodule

// File: rtl/uart_rx_controller.sv
// Purpose: UART RX front end - sync, start qualify, bit strobes, parity/stop check.
// Latency: 2-flop sync + registered outputs; deser_en one cycle after each bit's last tick.
// Backpressure: none; deserializer must accept every deser_en/success strobe.
module uart_rx_controller
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_in,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               parity_en,
    input  logic               parity_type,
    output logic               sampled_bit,
    output logic               deser_en,
    output logic               success,
    output logic               parity_error,
    output logic               stop_error,
    output logic               busy
);

    localparam int                 BW       = $clog2(DATA_WIDTH);
    localparam logic [PRESC_W-1:0] ONE      = PRESC_W'(1);
    localparam logic [PRESC_W-1:0] PMIN     = PRESC_W'(PRESC_MIN);
    localparam logic [BW-1:0]      BIT_ONE  = BW'(1);
    localparam logic [BW-1:0]      BIT_LAST = BW'(DATA_WIDTH - 1);

    rx_state_t          state, state_nxt;
    logic               rx_meta, rx_sync;
    logic [PRESC_W-1:0] edge_cnt, presc_q, presc_norm, p_last;
    logic [BW-1:0]      bit_cnt;
    logic               par_en_q, par_type_q, par_acc, par_err_flag;
    logic               bit_last;
    logic               deser_en_nxt, success_nxt, parity_error_nxt, stop_error_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) {rx_meta, rx_sync} <= 2'b11;
        else     {rx_meta, rx_sync} <= {rx_in, rx_meta};
    end

    // Odd ratios round down so the midpoint taps stay symmetric.
    assign presc_norm = (prescale < PMIN) ? PMIN : {prescale[PRESC_W-1:1], 1'b0};
    assign p_last     = presc_q - ONE;
    assign bit_last   = (edge_cnt == p_last);

    uart_rx_data_sampler #(.PRESC_W(PRESC_W)) u_sampler (
        .clk         (clk),
        .rst         (rst),
        .rx_sync     (rx_sync),
        .edge_cnt    (edge_cnt),
        .presc       (presc_q),
        .sampled_bit (sampled_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt        = state;
        deser_en_nxt     = 1'b0;
        success_nxt      = 1'b0;
        parity_error_nxt = 1'b0;
        stop_error_nxt   = 1'b0;
        case (state)
            IDLE:   if (!rx_sync) state_nxt = START;
            START:  if (bit_last) state_nxt = sampled_bit ? IDLE : DATA;
            DATA: begin
                if (bit_last) begin
                    deser_en_nxt = 1'b1;
                    if (bit_cnt == BIT_LAST) state_nxt = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: if (bit_last) state_nxt = STOP;
            STOP: begin
                if (bit_last) begin
                    state_nxt        = IDLE;
                    stop_error_nxt   = !sampled_bit;
                    parity_error_nxt = par_err_flag;
                    success_nxt      = sampled_bit && !par_err_flag;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The detect cycle is bit-cycle 0, so the counter starts at 1 on entry to START.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt     <= '0;
            bit_cnt      <= '0;
            presc_q      <= '0;
            par_en_q     <= 1'b0;
            par_type_q   <= 1'b0;
            par_acc      <= 1'b0;
            par_err_flag <= 1'b0;
        end else if (state == IDLE) begin
            edge_cnt <= '0;
            if (!rx_sync) begin
                edge_cnt     <= ONE;
                bit_cnt      <= '0;
                presc_q      <= presc_norm;
                par_en_q     <= parity_en;
                par_type_q   <= parity_type;
                par_acc      <= 1'b0;
                par_err_flag <= 1'b0;
            end
        end else begin
            edge_cnt <= bit_last ? '0 : edge_cnt + ONE;
            if (state == DATA && bit_last) begin
                bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_ONE;
                par_acc <= par_acc ^ sampled_bit;
            end
            if (state == PARITY && bit_last &&
                (sampled_bit != (par_acc ^ (par_type_q == ODD))))
                par_err_flag <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deser_en     <= 1'b0;
            success      <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            deser_en     <= deser_en_nxt;
            success      <= success_nxt;
            parity_error <= parity_error_nxt;
            stop_error   <= stop_error_nxt;
            busy         <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed bench for uart_rx_controller: frames driven bit-by-bit, strobes logged
// with their edge index and compared against the frame timing formulas.
module tb_uart_rx_controller;
    import uart_rx_pkg::*;

    localparam int DW = 8;
    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_in = 1'b1;
    logic [PW-1:0] prescale = 6'd8;
    logic          parity_en = 1'b0;
    logic          parity_type = 1'b0;
    logic          sampled_bit, deser_en, success, parity_error, stop_error, busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int   de_cyc[$];
    logic de_bit[$];
    int   succ_cyc[$];
    int   perr_cyc[$];
    int   serr_cyc[$];
    int   rise_cyc[$];
    int   fall_cyc[$];
    logic busy_d = 1'b0;

    uart_rx_controller #(.DATA_WIDTH(DW), .PRESC_W(PW)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_in        (rx_in),
        .prescale     (prescale),
        .parity_en    (parity_en),
        .parity_type  (parity_type),
        .sampled_bit  (sampled_bit),
        .deser_en     (deser_en),
        .success      (success),
        .parity_error (parity_error),
        .stop_error   (stop_error),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // cyc = index of the most recent rising edge
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (deser_en) begin
            de_cyc.push_back(cyc);
            de_bit.push_back(sampled_bit);
        end
        if (success)      succ_cyc.push_back(cyc);
        if (parity_error) perr_cyc.push_back(cyc);
        if (stop_error)   serr_cyc.push_back(cyc);
        if (busy && !busy_d) rise_cyc.push_back(cyc);
        if (!busy && busy_d) fall_cyc.push_back(cyc);
        busy_d <= busy;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        de_cyc.delete();
        de_bit.delete();
        succ_cyc.delete();
        perr_cyc.delete();
        serr_cyc.delete();
        rise_cyc.delete();
        fall_cyc.delete();
    endtask

    // Called at a falling edge; k is the first rising edge that sees the start bit.
    task automatic send_frame(input logic [7:0] data, input int p, input logic pen,
                              input logic pbit, input logic sbit,
                              input int gbit, input int goff, output int k);
        logic bits[11];
        int   n;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = data[i];
        n = 9;
        if (pen) begin
            bits[n] = pbit;
            n++;
        end
        bits[n] = sbit;
        n++;
        prescale  = PW'(p);
        parity_en = pen;
        k = cyc + 1;
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < p; c++) begin
                rx_in = (b == gbit && c == goff) ? ~bits[b] : bits[b];
                @(negedge clk);
            end
        end
    endtask

    task automatic check_frame(input string tag, input int k, input int p, input logic pen,
                               input logic [7:0] data, input int e_succ, input int e_perr,
                               input int e_serr);
        int tc;
        tc = k + 1 + (10 + int'(pen)) * p;
        chk({tag, ".de_count"}, de_cyc.size(), 8);
        for (int i = 0; i < de_cyc.size() && i < 8; i++) begin
            chk($sformatf("%s.de_cyc%0d", tag, i), de_cyc[i], k + 1 + (i + 2) * p);
            chk($sformatf("%s.de_bit%0d", tag, i), de_bit[i], data[i]);
        end
        chk({tag, ".succ_n"}, succ_cyc.size(), e_succ);
        chk({tag, ".perr_n"}, perr_cyc.size(), e_perr);
        chk({tag, ".serr_n"}, serr_cyc.size(), e_serr);
        if (succ_cyc.size() > 0) chk({tag, ".succ_cyc"}, succ_cyc[0], tc);
        if (perr_cyc.size() > 0) chk({tag, ".perr_cyc"}, perr_cyc[0], tc);
        if (serr_cyc.size() > 0) chk({tag, ".serr_cyc"}, serr_cyc[0], tc);
        chk({tag, ".rise_n"}, rise_cyc.size(), 1);
        if (rise_cyc.size() > 0) chk({tag, ".busy_rise"}, rise_cyc[0], k + 2);
        chk({tag, ".fall_n"}, fall_cyc.size(), 1);
        if (fall_cyc.size() > 0) chk({tag, ".busy_fall"}, fall_cyc[0], tc);
        chk({tag, ".busy_end"}, busy, 1'b0);
    endtask

    initial begin
        int k, k2;
        logic [15:0] b2b;

        #1;
        chk("rst.sampled_bit", sampled_bit, 1'b0);
        chk("rst.deser_en", deser_en, 1'b0);
        chk("rst.success", success, 1'b0);
        chk("rst.parity_error", parity_error, 1'b0);
        chk("rst.stop_error", stop_error, 1'b0);
        chk("rst.busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // clean 0xA5 at P=8: success at k+81
        clr();
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, -1, 0, k);
        repeat (6) @(negedge clk);
        check_frame("a5", k, 8, 1'b0, 8'hA5, 1, 0, 0);
        chk("a5.succ_abs", succ_cyc.size() > 0 ? succ_cyc[0] - k : -1, 81);

        // even parity, P=16, 0x3C: parity bit 0 good, 1 bad
        parity_type = EVEN;
        repeat (5) @(negedge clk);
        clr();
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, -1, 0, k);
        repeat (6) @(negedge clk);
        check_frame("even_ok", k, 16, 1'b1, 8'h3C, 1, 0, 0);

        repeat (5) @(negedge clk);
        clr();
        send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, -1, 0, k);
        repeat (6) @(negedge clk);
        check_frame("even_bad", k, 16, 1'b1, 8'h3C, 0, 1, 0);

        // odd parity, P=8, 0x3C: parity bit 1 good
        parity_type = ODD;
        repeat (5) @(negedge clk);
        clr();
        send_frame(8'h3C, 8, 1'b1, 1'b1, 1'b1, -1, 0, k);
        repeat (6) @(negedge clk);
        check_frame("odd_ok", k, 8, 1'b1, 8'h3C, 1, 0, 0);
        parity_type = EVEN;

        // stop bit low
        repeat (5) @(negedge clk);
        clr();
        send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b0, -1, 0, k);
        rx_in = 1'b1;
        repeat (6) @(negedge clk);
        check_frame("stop_err", k, 8, 1'b0, 8'hFF, 0, 0, 1);

        // 3-cycle glitch at P=16: aborts at k+17, no strobes
        repeat (5) @(negedge clk);
        clr();
        prescale = 6'd16;
        parity_en = 1'b0;
        k = cyc + 1;
        rx_in = 1'b0;
        repeat (3) @(negedge clk);
        rx_in = 1'b1;
        repeat (30) @(negedge clk);
        chk("glitch.de_n", de_cyc.size(), 0);
        chk("glitch.succ_n", succ_cyc.size(), 0);
        chk("glitch.serr_n", serr_cyc.size(), 0);
        chk("glitch.rise_n", rise_cyc.size(), 1);
        if (rise_cyc.size() > 0) chk("glitch.busy_rise", rise_cyc[0], k + 2);
        chk("glitch.fall_n", fall_cyc.size(), 1);
        if (fall_cyc.size() > 0) chk("glitch.busy_fall", fall_cyc[0], k + 17);
        chk("glitch.busy_end", busy, 1'b0);

        // one low sample at the midpoint of data bit 3 (all ones) still votes 1
        clr();
        send_frame(8'hFF, 16, 1'b0, 1'b0, 1'b1, 4, 8, k);
        repeat (6) @(negedge clk);
        check_frame("vote", k, 16, 1'b0, 8'hFF, 1, 0, 0);

        // back-to-back 0x55, 0xAA at P=32, no idle between frames
        repeat (5) @(negedge clk);
        clr();
        send_frame(8'h55, 32, 1'b0, 1'b0, 1'b1, -1, 0, k);
        send_frame(8'hAA, 32, 1'b0, 1'b0, 1'b1, -1, 0, k2);
        repeat (6) @(negedge clk);
        b2b = 16'hAA55;
        chk("b2b.de_n", de_cyc.size(), 16);
        for (int i = 0; i < de_bit.size() && i < 16; i++)
            chk($sformatf("b2b.de_bit%0d", i), de_bit[i], b2b[i]);
        if (de_cyc.size() > 8) chk("b2b.de_cyc8", de_cyc[8], k2 + 1 + 2 * 32);
        chk("b2b.succ_n", succ_cyc.size(), 2);
        if (succ_cyc.size() > 0) chk("b2b.succ0", succ_cyc[0], k + 321);
        if (succ_cyc.size() > 1) chk("b2b.succ1", succ_cyc[1], k2 + 321);
        chk("b2b.err_n", perr_cyc.size() + serr_cyc.size(), 0);

        // reset during data bit 4 of an all-ones frame
        repeat (5) @(negedge clk);
        clr();
        prescale = 6'd8;
        rx_in = 1'b0;
        repeat (8) @(negedge clk);
        rx_in = 1'b1;
        repeat (36) @(negedge clk);
        chk("mid.busy_pre", busy, 1'b1);
        chk("mid.bit_pre", sampled_bit, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid.busy", busy, 1'b0);
        chk("mid.sampled_bit", sampled_bit, 1'b0);
        chk("mid.deser_en", deser_en, 1'b0);
        chk("mid.success", success, 1'b0);
        chk("mid.parity_error", parity_error, 1'b0);
        chk("mid.stop_error", stop_error, 1'b0);
        chk("mid.succ_n", succ_cyc.size(), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        clr();
        send_frame(8'h12, 8, 1'b0, 1'b0, 1'b1, -1, 0, k);
        repeat (6) @(negedge clk);
        check_frame("after_rst", k, 8, 1'b0, 8'h12, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_controller.md
# uart_rx_controller

Front-end control stage of the UART receiver. It synchronises the serial line, detects and qualifies the start bit, and majority-votes each bit at the oversampling midpoint. It checks parity and stop bits and drives the bit-serial handshake into the downstream RX deserializer. Per frame it produces one `deser_en` pulse per data bit, LSB first, then a single `success` pulse on a clean frame so the deserializer latches its parallel word.

## Interface
- `DATA_WIDTH`, 8, data bits per frame
- `PRESC_W`, 6, width of the `prescale` input
- `clk`  in  1  receiver clock
- `rst`  in  1  asynchronous, active-high reset
- `rx_in`  in  1  raw serial line; idles high
- `prescale`  in  PRESC_W  oversampling ratio (clocks per bit); legal values 8/16/32
- `parity_en`  in  1  1 = frame carries a parity bit
- `parity_type`  in  1  0 = even, 1 = odd
- `sampled_bit`  out  1  majority-voted value of the current bit
- `deser_en`  out  1  one-cycle shift strobe to the deserializer
- `success`  out  1  one-cycle pulse: frame received without error
- `parity_error`  out  1  one-cycle pulse: parity mismatch
- `stop_error`  out  1  one-cycle pulse: stop bit sampled low
- `busy`  out  1  high while the FSM is not in IDLE

## Operation
- Reset: every flop clears; all outputs are 0. The synchroniser stages reset to 1 (line idle).
- `rx_in` passes through a 2-flop synchroniser to produce `rx_sync`. All logic uses `rx_sync` only.
- FSM states and transitions:
  - IDLE: `rx_sync`==0 → START. On this transition `prescale`, `parity_en` and `parity_type` are latched, and `edge_cnt` ← 1 (the detect cycle counts as bit-cycle 0).
  - START: at `edge_cnt`==P-1, `sampled_bit`==1 → IDLE (glitch, no outputs); otherwise → DATA.
  - DATA: at `edge_cnt`==P-1, pulse `deser_en` and increment `bit_cnt`. When `bit_cnt` reaches DATA_WIDTH-1, go to PARITY if `parity_en`, otherwise STOP.
  - PARITY: at `edge_cnt`==P-1, compare `sampled_bit` with the expected parity. On mismatch set the `parity_err_flag`. → STOP.
  - STOP: at `edge_cnt`==P-1, evaluate and → IDLE. Evaluation:
    - `sampled_bit`==0 → pulse `stop_error`.
    - Parity flag set → pulse `parity_error`.
    - Both errors are reported if both occurred.
    - Only when neither occurred → pulse `success`.
- `edge_cnt` counts 0..P-1 per bit and wraps to 0. `bit_cnt` has width clog2(DATA_WIDTH).
- P = latched prescale. Values <8 are treated as 8, and odd values are rounded down. Changing `prescale`, `parity_en` or `parity_type` mid-frame has no effect.
- Sampling: capture `rx_sync` at `edge_cnt` = P/2-1, P/2 and P/2+1. `sampled_bit` ← majority(3), registered at the P/2+1 cycle and held until the next bit's update.
- Parity accumulator: XOR of the voted data bits, updated on each `deser_en`. Expected bit = acc ^ `parity_type`.
- Back-to-back frames: IDLE can detect a new start in the cycle right after the STOP exit.
- Reset mid-frame returns to IDLE immediately. No pulses are emitted.

## Timing
- Let edge k be the first clock edge at which `rx_in` is sampled low. START is entered at edge k+2.
- The i-th `deser_en` (i = 0..DATA_WIDTH-1) is high during the cycle following edge k+1+(i+2)·P. `sampled_bit` is stable while it is high.
- Let F = 2+DATA_WIDTH+`parity_en` (bits per frame). `success`, `parity_error` and `stop_error` are high for one cycle following edge k+1+F·P. F = 10 without parity and 11 with parity.
- `busy` rises at edge k+2 and falls together with the terminal pulse (or with the glitch abort).
- All outputs are registered. No combinational path runs from inputs to outputs.

## Structure
- `uart_rx_pkg`:
  - state enum (IDLE, START, DATA, PARITY, STOP)
  - `PRESC_MIN` = 8
  - parity-type constants EVEN = 0, ODD = 1
- Sub-module `uart_rx_data_sampler`:
  - inputs: `clk`, `rst`, `rx_sync`, `edge_cnt`, P
  - output: `sampled_bit` (3-sample majority vote)
- The FSM, counters, parity and the synchroniser stay in `uart_rx_controller`.

## Test plan
- Clean frame: P=8, no parity, byte 0xA5 (LSB first). Expect `deser_en` values 1,0,1,0,0,1,0,1 at the Timing-section cycles, then `success` once at k+81, then `busy`=0.
- Even parity: P=16, `parity_en`=1, data 0x3C with parity bit 0 → `success`. Repeat with parity bit 1 → `parity_error` only, no `success`.
- Stop error: P=8, data 0xFF, stop bit driven 0 → `stop_error` pulse, no `success`, FSM returns to IDLE.
- Glitch: `rx_in` low for 3 cycles at P=16 → FSM returns to IDLE after 16 cycles with no `deser_en`. Majority check: one low sample inside a high data bit still votes 1.
- Back-to-back: two frames 0x55 then 0xAA with zero idle cycles at P=32 → two `success` pulses and 16 `deser_en` pulses.
- Mid-frame reset: assert `rst` during DATA bit 4 → all outputs 0 immediately. A following clean frame 0x12 → `success`.
